// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle between a CPU and the sequential divider.
// The master modport is the requester side, the slave modport is the divider.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider for DIV/DIVU, one quotient bit per clock.
// Operands are converted to magnitudes on start, divided unsigned, then signs are
// fixed up in a final FIX cycle. Results are held until the next done pulse.
// Optional feature macro: SEQ_DIVIDER_EARLY_OUT_EN -- skip the RUN phase when the
// divisor is zero or |dividend| < |divisor|.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q;       // partial remainder magnitude
    logic [WIDTH-1:0]   dvd_q;       // dividend magnitude, shifts into quotient magnitude
    logic [WIDTH-1:0]   dsr_q;       // divisor magnitude
    logic               qneg_q;
    logic               rneg_q;
    logic               dz_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   quotient_q;
    logic [WIDTH-1:0]   remainder_q;
    logic               div_by_zero_q;

    logic               dvd_neg_d;
    logic               dsr_neg_d;
    logic [WIDTH-1:0]   dvd_mag_d;
    logic [WIDTH-1:0]   dsr_mag_d;
    logic [WIDTH:0]     shift_d;
    logic [WIDTH-1:0]   diff_d;
    logic               ge_d;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    logic               early_d;
`endif

    // Operand magnitudes and one restoring step; WIDTH+1-bit compare/subtract so a
    // shifted remainder with its top bit set still compares correctly.
    always_comb begin
        dvd_neg_d = bus.is_signed & bus.dividend[WIDTH-1];
        dsr_neg_d = bus.is_signed & bus.divisor[WIDTH-1];
        dvd_mag_d = dvd_neg_d ? WIDTH'(-bus.dividend) : bus.dividend;
        dsr_mag_d = dsr_neg_d ? WIDTH'(-bus.divisor) : bus.divisor;
        shift_d   = {rem_q, dvd_q[WIDTH-1]};
        ge_d      = (shift_d >= {1'b0, dsr_q});
        diff_d    = WIDTH'(shift_d - {1'b0, dsr_q});
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
        early_d   = (bus.divisor == '0) || (dvd_mag_d < dsr_mag_d);
`endif
    end

    // Control FSM, iteration datapath and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            dvd_q         <= '0;
            dsr_q         <= '0;
            qneg_q        <= 1'b0;
            rneg_q        <= 1'b0;
            dz_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        dsr_q  <= dsr_mag_d;
                        qneg_q <= dvd_neg_d ^ dsr_neg_d;
                        rneg_q <= dvd_neg_d;
                        dz_q   <= (bus.divisor == '0);
                        cnt_q  <= CNT_W'(WIDTH);
                        busy_q <= 1'b1;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
                        if (early_d) begin
                            // quotient magnitude is 0, remainder magnitude is |dividend|
                            rem_q   <= dvd_mag_d;
                            dvd_q   <= '0;
                            state_q <= FIX;
                        end else begin
                            rem_q   <= '0;
                            dvd_q   <= dvd_mag_d;
                            state_q <= RUN;
                        end
`else
                        rem_q   <= '0;
                        dvd_q   <= dvd_mag_d;
                        state_q <= RUN;
`endif
                    end
                end
                RUN: begin
                    rem_q <= ge_d ? diff_d : shift_d[WIDTH-1:0];
                    dvd_q <= {dvd_q[WIDTH-2:0], ge_d};
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    // divide-by-zero forces an all-ones quotient; the remainder path
                    // already rebuilds the original dividend from its magnitude and sign
                    quotient_q    <= dz_q   ? '1 : (qneg_q ? WIDTH'(-dvd_q) : dvd_q);
                    remainder_q   <= rneg_q ? WIDTH'(-rem_q) : rem_q;
                    div_by_zero_q <= dz_q;
                    done_q        <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vector table plus hand-written start/reset corner sequences.
module tb_seq_divider;

    localparam int unsigned W = 32;
    localparam int unsigned LAT = W + 1;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_start(input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
    endtask

    // Waits (bounded) for done after the start edge has been taken; samples #1 after edges.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat = 0;
        busy_cyc = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int busy_cyc);
        @(negedge clk);
        drive_start(s, a, b);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat, busy_cyc);
    endtask

    initial begin
        int lat;
        int bc;
        bit seen;

        errors = 0;
        checks = 0;
        bus.start = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;

        vecs[0]  = '{"u100_7",      1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{"s-7_2",       1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        vecs[2]  = '{"s7_-2",       1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
        vecs[3]  = '{"s_min_-1",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        vecs[4]  = '{"u_max_1",     1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[5]  = '{"u_dz",        1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
        vecs[6]  = '{"s_dz",        1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
        vecs[7]  = '{"s_dz_neg",    1'b1, 32'h8000_0005,  32'd0,          32'hFFFF_FFFF,  32'h8000_0005,  1'b1};
        vecs[8]  = '{"u_small",     1'b0, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFE,  1'b0};
        vecs[9]  = '{"u_80_3",      1'b0, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,          1'b0};
        vecs[10] = '{"s-100_-7",    1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};
        vecs[11] = '{"s5_7",        1'b1, 32'd5,          32'd7,          32'd0,          32'd5,          1'b0};
        vecs[12] = '{"u_max_2",     1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1,          1'b0};

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_q",    bus.quotient, 32'd0);
        check("rst_r",    bus.remainder, 32'd0);
        check("rst_dz",   32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 13; i++) begin
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, bc);
            check({vecs[i].name, "_lat"},  32'(lat), 32'(LAT));
            check({vecs[i].name, "_busy"}, 32'(bc),  32'(LAT));
            check({vecs[i].name, "_q"},    bus.quotient, vecs[i].q);
            check({vecs[i].name, "_r"},    bus.remainder, vecs[i].r);
            check({vecs[i].name, "_dz"},   32'(bus.div_by_zero), 32'(vecs[i].dz));
            @(posedge clk); #1;
            check({vecs[i].name, "_done_1cyc"}, 32'(bus.done), 32'd0);
        end

        // start pulses at +5 and +20 of a running division are ignored
        @(negedge clk);
        drive_start(1'b0, 32'd100, 32'd7);
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 100) begin
            if (lat == 5 || lat == 20) drive_start(1'b1, 32'd50, 32'd5);
            else bus.start = 1'b0;
            if (lat == 10) check("hold_q_in_run", bus.remainder, 32'd1);
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        check("ign_lat", 32'(lat), 32'(LAT));
        check("ign_q",   bus.quotient, 32'd14);
        check("ign_r",   bus.remainder, 32'd2);

        // reset in the middle of a division aborts it with no done pulse
        @(negedge clk);
        drive_start(1'b1, 32'hFFFF_FFF9, 32'd2);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_q",    bus.quotient, 32'd0);
        check("abort_r",    bus.remainder, 32'd0);
        check("abort_dz",   32'(bus.div_by_zero), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done || bus.busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        // start in the done cycle is accepted
        run_div(1'b0, 32'd100, 32'd7, lat, bc);
        check("b2b_first_q", bus.quotient, 32'd14);
        drive_start(1'b1, 32'd7, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_done_low", 32'(bus.done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_hold_q", bus.quotient, 32'd14);
        wait_done(lat, bc);
        lat = lat + 3;
        check("b2b_lat", 32'(lat), 32'(LAT - 3 + 3));
        check("b2b_q", bus.quotient, 32'hFFFF_FFFD);
        check("b2b_r", bus.remainder, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin a division; sampled only in IDLE.
REQ-005 The block SHALL have port is_signed, input, 1, 1 = two's-complement (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-006 The block SHALL have port dividend, input, WIDTH, numerator; sampled with start.
REQ-007 The block SHALL have port divisor, input, WIDTH, denominator; sampled with start.
REQ-008 The block SHALL have port busy, output, 1, high whenever state is not IDLE; the CPU stalls its PC on it.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse marking that quotient and remainder have just updated.
REQ-010 The block SHALL have port quotient, output, WIDTH, result destined for LO.
REQ-011 The block SHALL have port remainder, output, WIDTH, result destined for HI.
REQ-012 The block SHALL have port div_by_zero, output, 1, high with the results of a divisor==0 operation; held with the results.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and FIX; busy = (state != IDLE).
REQ-014 In IDLE with start=1 (edge k), the block SHALL latch |dividend|, |divisor|, the quotient sign (signs differ, signed mode) and the remainder sign (dividend sign, signed mode), clear the partial remainder, load iteration count = WIDTH and enter RUN.
REQ-015 In RUN, each edge SHALL perform one restoring step: shift {partial remainder, dividend magnitude} left 1; if the shifted partial remainder >= |divisor|, subtract it and shift in quotient bit 1, else shift in 0; decrement the count.
REQ-016 The block SHALL use a WIDTH+1-bit subtractor so that |-2^(WIDTH-1)| compares correctly.
REQ-017 When the count reaches 0 (edge k+WIDTH), the block SHALL enter FIX.
REQ-018 In FIX (edge k+WIDTH+1), the block SHALL negate the quotient magnitude if the quotient sign is set, negate the remainder magnitude if the remainder sign is set, register quotient, remainder and div_by_zero, pulse done for exactly the following cycle, and return to IDLE.
REQ-019 Without the early-out feature, latency from the start edge to valid results SHALL be exactly WIDTH+1 edges, with busy high for WIDTH+1 cycles.
REQ-020 start asserted while busy=1 SHALL be ignored, with no effect on state or latched operands.
REQ-021 start asserted in the cycle where done=1 (state IDLE) SHALL be accepted.
REQ-022 quotient, remainder and div_by_zero SHALL hold their values from one done pulse until the next done pulse or reset; they SHALL NOT change during RUN.
REQ-023 For divisor==0, the block SHALL produce quotient = all ones, remainder = original dividend and div_by_zero=1, regardless of is_signed, with the same latency as a normal division.
REQ-024 For signed -2^(WIDTH-1) / -1, the block SHALL produce quotient 0x80000000, remainder 0 and div_by_zero=0, with no exception.
REQ-025 Remainder sign SHALL always equal the dividend sign (or remainder is 0), and |remainder| < |divisor| SHALL hold.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL set state to IDLE, busy 0, done 0, quotient 0, remainder 0, div_by_zero 0 and clear all internal registers.
REQ-027 rst SHALL take priority over start and over any in-progress RUN or FIX; an aborted division SHALL produce no done pulse.

Configuration
REQ-028 When the macro SEQ_DIVIDER_EARLY_OUT_EN is defined and, in IDLE with start, divisor==0 or |dividend| < |divisor|, the block SHALL go directly from IDLE to FIX, producing quotient magnitude 0 and remainder magnitude |dividend| (or the REQ-023 values for divisor==0), with done two edges after the start edge.
REQ-029 When SEQ_DIVIDER_EARLY_OUT_EN is undefined, the block SHALL never skip RUN, and latency SHALL always be WIDTH+1 edges.

Verification
REQ-030 Unsigned 100 / 7 -> quotient 14, remainder 2, div_by_zero 0, done exactly 33 edges after start, busy high 33 cycles.
REQ-031 Signed -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); signed 7 / -2 -> quotient -3, remainder 1.
REQ-032 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-033 Divisor 0, dividend 0x12345678 -> quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero 1; with SEQ_DIVIDER_EARLY_OUT_EN, done 2 edges after start, otherwise 33 edges after start.
REQ-034 start pulsed at cycles +5 and +20 of a running division -> ignored, first results unchanged; rst at cycle +10 -> busy 0, outputs 0, no done; a new start in the done cycle -> accepted, busy stays high.
